// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receive path: FIFO geometry, irq threshold
// and idle-timeout length, kept in one place so they follow clk/baud changes.
// Latency: n/a (constants only). Backpressure: n/a.
package uart_rx_fifo_pkg;

  localparam int UART_FIFO_DW     = 8;     // byte width
  localparam int UART_FIFO_AW     = 4;     // 16-entry buffer
  localparam int UART_FIFO_THRESH = 8;     // fill level that raises irq
  localparam int UART_TIMEOUT_CYC = 4340;  // idle clk cycles before timeout irq
  localparam int UART_TIMEOUT_TW  = 13;    // 2**13 > 4340

endpackage

// File: rtl/uart_fifo_mem.sv
// DW x 2**AW register array: one synchronous write port, one async read port.
// Latency: write visible on rdata the cycle after the we edge; read is combinational.
// Backpressure: none; the caller guards we against overwriting live entries.
//
// Ports:
//   clk            clock
//   we/waddr/wdata write enable, address and data (captured on posedge clk)
//   raddr/rdata    asynchronous read address and data
module uart_fifo_mem #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] r_mem [2**AW];

  // No reset: contents are only observed through valid pointers.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: captures a byte per rx_valid rising edge, presents the head
// first-word-fall-through, raises irq on fill level, idle timeout or overrun.
// Latency: pushed byte visible on rd_data/level the cycle after the push edge;
// irq is registered. Backpressure: none upstream; a push into a full FIFO with
// no coincident pop is dropped and latches overrun.
//
// Ports:
//   clk, RST        clock, asynchronous active-high reset
//   rx_data/valid   byte and level done-strobe from UART_RX
//   pop, clr        consume head (pulse), synchronous flush
//   rd_data         head byte (0 when empty)
//   empty/full/level occupancy status
//   overrun, irq    sticky drop flag, registered interrupt
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DW      = UART_FIFO_DW,
  parameter int AW      = UART_FIFO_AW,
  parameter int THRESH  = UART_FIFO_THRESH,
  parameter int TIMEOUT = UART_TIMEOUT_CYC,
  parameter int TW      = UART_TIMEOUT_TW
) (
  input  logic          clk,
  input  logic          RST,
  input  logic [DW-1:0] rx_data,
  input  logic          rx_valid,
  input  logic          pop,
  input  logic          clr,
  output logic [DW-1:0] rd_data,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   level,
  output logic          overrun,
  output logic          irq
);

  localparam logic [AW:0]   L_PTR_ONE = (AW+1)'(1);
  localparam logic [AW:0]   L_THRESH  = (AW+1)'(THRESH);
  localparam logic [TW-1:0] L_TIMEOUT = TW'(TIMEOUT);
  localparam logic [TW-1:0] L_CNT_ONE = TW'(1);

  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic          r_rx_valid_q;
  logic          r_overrun;
  logic          r_irq;
  logic [TW-1:0] r_to_cnt;

  logic [AW:0]   w_wr_ptr_nxt;
  logic [AW:0]   w_rd_ptr_nxt;
  logic [AW:0]   w_level_nxt;
  logic          w_push_req;
  logic          w_do_push;
  logic          w_do_pop;
  logic          w_ovr_set;
  logic          w_overrun_nxt;
  logic          w_cnt_clr;
  logic          w_to_hit;
  logic          w_irq_nxt;
  logic          w_empty;
  logic          w_full;
  logic [DW-1:0] w_mem_rdata;

  always_comb begin
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;

    // rx_valid is a level that may be held; only its rising edge is a byte.
    w_push_req = rx_valid & ~r_rx_valid_q;

    w_empty = (r_wr_ptr == r_rd_ptr);
    w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
              (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // A pop in the same cycle frees the slot a push into a full FIFO needs;
    // a pop when full is always legal since full implies non-empty.
    w_do_pop  = pop & ~w_empty & ~clr;
    w_do_push = w_push_req & ~clr & (~w_full | pop);
    w_ovr_set = w_push_req & ~clr & w_full & ~pop;

    if (clr) begin
      w_wr_ptr_nxt = '0;
      w_rd_ptr_nxt = '0;
    end else begin
      if (w_do_push) w_wr_ptr_nxt = r_wr_ptr + L_PTR_ONE;
      if (w_do_pop)  w_rd_ptr_nxt = r_rd_ptr + L_PTR_ONE;
    end

    w_level_nxt   = w_wr_ptr_nxt - w_rd_ptr_nxt;
    w_overrun_nxt = clr ? 1'b0 : (r_overrun | w_ovr_set);

    w_cnt_clr = clr | w_push_req | pop | w_empty;
    w_to_hit  = (r_to_cnt == L_TIMEOUT);

    // The timeout term is dropped in the cycle its counter restarts so that a
    // pop, push or flush removes the timeout cause at the very next edge.
    w_irq_nxt = (w_level_nxt >= L_THRESH) | (w_to_hit & ~w_cnt_clr) | w_overrun_nxt;
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_rx_valid_q <= 1'b0;
      r_overrun    <= 1'b0;
      r_irq        <= 1'b0;
      r_to_cnt     <= '0;
    end else begin
      r_wr_ptr     <= w_wr_ptr_nxt;
      r_rd_ptr     <= w_rd_ptr_nxt;
      r_rx_valid_q <= rx_valid;
      r_overrun    <= w_overrun_nxt;
      r_irq        <= w_irq_nxt;
      if (w_cnt_clr) begin
        r_to_cnt <= '0;
      end else if (!w_to_hit) begin
        r_to_cnt <= r_to_cnt + L_CNT_ONE;
      end
    end
  end

  uart_fifo_mem #(
    .DW (DW),
    .AW (AW)
  ) u_mem (
    .clk   (clk),
    .we    (w_do_push),
    .waddr (r_wr_ptr[AW-1:0]),
    .wdata (rx_data),
    .raddr (r_rd_ptr[AW-1:0]),
    .rdata (w_mem_rdata)
  );

  assign empty   = w_empty;
  assign full    = w_full;
  assign level   = r_wr_ptr - r_rd_ptr;
  assign rd_data = w_empty ? '0 : w_mem_rdata;
  assign overrun = r_overrun;
  assign irq     = r_irq;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: vector table, directed corner cases,
// and randomized traffic against a queue-based reference model.
// Latency: n/a. Backpressure: n/a.
module tb_uart_rx_fifo;
  import uart_rx_fifo_pkg::*;

  localparam int DW      = UART_FIFO_DW;
  localparam int AW      = UART_FIFO_AW;
  localparam int DEPTH   = 2**AW;
  localparam int THRESH  = UART_FIFO_THRESH;
  localparam int TIMEOUT = UART_TIMEOUT_CYC;

  logic          clk = 1'b0;
  logic          RST;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          pop;
  logic          clr;
  logic [DW-1:0] rd_data;
  logic          empty;
  logic          full;
  logic [AW:0]   level;
  logic          overrun;
  logic          irq;

  uart_rx_fifo dut (
    .clk      (clk),
    .RST      (RST),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .pop      (pop),
    .clr      (clr),
    .rd_data  (rd_data),
    .empty    (empty),
    .full     (full),
    .level    (level),
    .overrun  (overrun),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a byte queue plus an idle-cycle count.
  byte unsigned m_q[$];
  bit           m_ovr;
  bit           m_irq;
  bit           m_prev_rv;
  int           m_idle;

  function automatic void m_reset();
    m_q.delete();
    m_ovr     = 1'b0;
    m_irq     = 1'b0;
    m_prev_rv = 1'b0;
    m_idle    = 0;
  endfunction

  function automatic void model_step(input bit rv, input logic [7:0] d,
                                     input bit p, input bit c);
    bit preq;
    bit was_empty;
    preq      = rv && !m_prev_rv;
    m_prev_rv = rv;
    if (c) begin
      m_q.delete();
      m_ovr  = 1'b0;
      m_idle = 0;
    end else begin
      was_empty = (m_q.size() == 0);
      if (p && !was_empty) void'(m_q.pop_front());
      if (preq) begin
        if (m_q.size() < DEPTH) m_q.push_back(d);
        else m_ovr = 1'b1;
      end
      if (preq || p || was_empty) m_idle = 0;
      else m_idle++;
    end
    m_irq = (m_q.size() >= THRESH) || m_ovr || (m_idle > TIMEOUT);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_model();
    int exp_rd;
    exp_rd = (m_q.size() == 0) ? 0 : int'(m_q[0]);
    check("mdl_level",   int'(level),   m_q.size());
    check("mdl_rd_data", int'(rd_data), exp_rd);
    check("mdl_empty",   int'(empty),   int'(m_q.size() == 0));
    check("mdl_full",    int'(full),    int'(m_q.size() == DEPTH));
    check("mdl_overrun", int'(overrun), int'(m_ovr));
    check("mdl_irq",     int'(irq),     int'(m_irq));
  endtask

  // Drive inputs away from the edge, clock once, advance the model, check.
  task automatic step(input bit rv, input logic [7:0] d, input bit p, input bit c);
    rx_valid = rv;
    rx_data  = d;
    pop      = p;
    clr      = c;
    @(posedge clk);
    model_step(rv, d, p, c);
    #1;
    check_model();
  endtask

  task automatic push_byte(input logic [7:0] d);
    step(1'b1, d, 1'b0, 1'b0);
    step(1'b0, d, 1'b0, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_level"},   int'(level),   0);
    check({tag, "_empty"},   int'(empty),   1);
    check({tag, "_full"},    int'(full),    0);
    check({tag, "_rd_data"}, int'(rd_data), 0);
    check({tag, "_overrun"}, int'(overrun), 0);
    check({tag, "_irq"},     int'(irq),     0);
  endtask

  typedef struct {
    bit         rv;
    logic [7:0] d;
    bit         p;
    bit         c;
    int         exp_level;
    int         exp_rd;
    bit         exp_empty;
    bit         exp_irq;
  } vec_t;

  localparam int NVEC = 13;
  vec_t tbl[NVEC];

  function automatic vec_t mk(input bit rv, input logic [7:0] d, input bit p,
                              input bit c, input int lvl, input int rd,
                              input bit emp, input bit iq);
    vec_t v;
    v.rv = rv; v.d = d; v.p = p; v.c = c;
    v.exp_level = lvl; v.exp_rd = rd; v.exp_empty = emp; v.exp_irq = iq;
    return v;
  endfunction

  initial begin
    int n;
    int exp_b;
    bit rv_state;
    int pop_pct;

    tbl[0]  = mk(1, 8'h41, 0, 0, 1, 8'h41, 0, 0);  // held rx_valid: one push
    tbl[1]  = mk(1, 8'h41, 0, 0, 1, 8'h41, 0, 0);
    tbl[2]  = mk(1, 8'h41, 0, 0, 1, 8'h41, 0, 0);
    tbl[3]  = mk(1, 8'h41, 0, 0, 1, 8'h41, 0, 0);
    tbl[4]  = mk(1, 8'h41, 0, 0, 1, 8'h41, 0, 0);
    tbl[5]  = mk(0, 8'h00, 0, 0, 1, 8'h41, 0, 0);
    tbl[6]  = mk(1, 8'h42, 0, 0, 2, 8'h41, 0, 0);
    tbl[7]  = mk(0, 8'h00, 1, 0, 1, 8'h42, 0, 0);
    tbl[8]  = mk(1, 8'h43, 1, 0, 1, 8'h43, 0, 0);  // push+pop, non-empty
    tbl[9]  = mk(0, 8'h00, 1, 0, 0, 8'h00, 1, 0);
    tbl[10] = mk(0, 8'h00, 1, 0, 0, 8'h00, 1, 0);  // pop while empty
    tbl[11] = mk(1, 8'h44, 1, 0, 1, 8'h44, 0, 0);  // empty + push + pop
    tbl[12] = mk(0, 8'h00, 0, 1, 0, 8'h00, 1, 0);  // flush

    RST = 1'b1; rx_valid = 1'b0; rx_data = '0; pop = 1'b0; clr = 1'b0;
    m_reset();
    #12;
    check_reset_outputs("reset");
    #10;
    RST = 1'b0;

    // Vector table
    for (int i = 0; i < NVEC; i++) begin
      step(tbl[i].rv, tbl[i].d, tbl[i].p, tbl[i].c);
      check($sformatf("tbl%0d_level", i), int'(level),   tbl[i].exp_level);
      check($sformatf("tbl%0d_rd", i),    int'(rd_data), tbl[i].exp_rd);
      check($sformatf("tbl%0d_empty", i), int'(empty),   int'(tbl[i].exp_empty));
      check($sformatf("tbl%0d_irq", i),   int'(irq),     int'(tbl[i].exp_irq));
    end

    // Fill to full, then overrun
    for (int i = 0; i < DEPTH; i++) push_byte(8'(i));
    check("fill_full",  int'(full),  1);
    check("fill_level", int'(level), 16);
    check("fill_irq",   int'(irq),   1);
    push_byte(8'hAA);
    check("ovr_flag",  int'(overrun), 1);
    check("ovr_level", int'(level),   16);
    check("ovr_head",  int'(rd_data), 0);

    // Full + push + pop in the same cycle, then drain in order
    step(0, 0, 0, 1);
    for (int i = 0; i < DEPTH; i++) push_byte(8'(i));
    step(1, 8'h55, 1, 0);
    step(0, 8'h55, 0, 0);
    check("pp_level",   int'(level),   16);
    check("pp_overrun", int'(overrun), 0);
    check("pp_head",    int'(rd_data), 1);
    for (int i = 0; i < DEPTH; i++) begin
      exp_b = (i < DEPTH - 1) ? i + 1 : 8'h55;
      check($sformatf("drain%0d", i), int'(rd_data), exp_b);
      step(0, 0, 1, 0);
    end
    check("drain_empty", int'(empty), 1);
    step(0, 0, 1, 0);
    check("xpop_level", int'(level), 0);
    check("xpop_empty", int'(empty), 1);

    // Idle timeout
    push_byte(8'h10);
    push_byte(8'h11);
    step(1, 8'h12, 0, 0);
    n = 0;
    while (!irq && n < TIMEOUT + 100) begin
      step(0, 0, 0, 0);
      n++;
    end
    check("to_rise_cycles", n, TIMEOUT + 1);
    step(0, 0, 1, 0);
    check("to_pop_irq", int'(irq), 0);
    n = 0;
    while (!irq && n < TIMEOUT + 100) begin
      step(0, 0, 0, 0);
      n++;
    end
    check("to_restart_cycles", n, TIMEOUT + 1);

    // Flush with coincident push
    step(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) push_byte(8'(8'h20 + i));
    check("clr_pre_level", int'(level), 5);
    step(1, 8'h77, 0, 1);
    check("clr_level",   int'(level),   0);
    check("clr_empty",   int'(empty),   1);
    check("clr_overrun", int'(overrun), 0);
    check("clr_irq",     int'(irq),     0);
    step(0, 8'h77, 0, 0);
    check("clr_nopush_level", int'(level), 0);

    // Asynchronous reset mid-stream
    for (int i = 0; i < DEPTH; i++) push_byte(8'(8'h30 + i));
    push_byte(8'hAB);
    for (int i = 0; i < 9; i++) step(0, 0, 1, 0);
    check("arst_pre_level",   int'(level),   7);
    check("arst_pre_overrun", int'(overrun), 1);
    #3;
    RST = 1'b1;
    #1;
    check_reset_outputs("arst");
    m_reset();
    rx_valid = 1'b0; pop = 1'b0; clr = 1'b0;
    @(posedge clk);
    #1;
    RST = 1'b0;

    // Pointer wrap: 40 push/pop pairs
    for (int i = 0; i < 40; i++) begin
      push_byte(8'($urandom));
      step(0, 0, 1, 0);
    end
    check("wrap_level", int'(level), 0);
    check("wrap_empty", int'(empty), 1);

    // Randomized traffic against the model
    rv_state = 1'b0;
    pop_pct  = 25;
    for (int i = 0; i < 4000; i++) begin
      if (i % 500 == 0) pop_pct = (pop_pct == 25) ? 70 : 25;
      if ($urandom_range(0, 2) == 0) begin
        rv_state = ~rv_state;
        if (rv_state) rx_data = 8'($urandom);
      end
      step(rv_state, rx_data, $urandom_range(0, 99) < pop_pct,
           $urandom_range(0, 299) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
